triad_gbe_packer: RTL and testbench

- Downstream consumer of the comparator-fiber receiver's 48-bit async compfifo, on the fabric side.
- Each time the receiver captures a burst of 3 triads (9 × 48-bit words), this block drains them into one framed 16-bit GbE transmit packet: preamble, header, data, checksum, end marker.
- Runs entirely in the fabric clock domain.
- Drives the FIFO read enable and feeds the GbE tx word stream through a valid/ready handshake.

---
 rtl/triad_gbe_pkg.sv | 29 ++
 rtl/triad_fifo_fetch.sv | 62 ++++++
 rtl/triad_gbe_packer.sv | 182 ++++++++++++++++++
 tb/tb_triad_gbe_packer.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/triad_gbe_pkg.sv
// Shared states and constants for the triad GbE packer.
// TRIAD_TIMESTAMP_EN adds the timestamp state to the enum.
package triad_gbe_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_CNT,
`ifdef TRIAD_TIMESTAMP_EN
        ST_TS,
`endif
        ST_FETCH,
        ST_DATA,
        ST_CSUM,
        ST_EOP
    } state_t;

    localparam logic [15:0] PREAMBLE_WORD    = 16'h50BC;
    localparam logic [15:0] EOP_WORD         = 16'hF7FE;
    localparam logic [15:0] HDR_MARK_DEFAULT = 16'hC0DE;
    localparam logic [15:0] PAD_WORD_DEFAULT = 16'hDEAD;
    localparam int unsigned BEATS_PER_WORD   = 3;

    function automatic logic [47:0] pad_fill(input logic [15:0] pad);
        return {pad, pad, pad};
    endfunction

endpackage

// File: rtl/triad_fifo_fetch.sv
// Fetches one 48-bit compfifo word per request: read pulse, 1-cycle capture,
// stall timeout that substitutes a padded word; padding mode skips the FIFO.
module triad_fifo_fetch
    import triad_gbe_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = 255,
    parameter logic [15:0] PAD_WORD      = PAD_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        padding,
    input  logic        fifo_empty,
    input  logic [47:0] fifo_dout,
    output logic        fifo_rd_en,
    output logic [47:0] hold,
    output logic        word_ready,
    output logic        timed_out
);

    localparam int unsigned SW = $clog2(STALL_TIMEOUT + 1);

    logic [SW-1:0] stall;
    logic          capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_rd_en <= 1'b0;
            capture    <= 1'b0;
            hold       <= '0;
            word_ready <= 1'b0;
            timed_out  <= 1'b0;
            stall      <= '0;
        end else begin
            fifo_rd_en <= 1'b0;
            word_ready <= 1'b0;
            timed_out  <= 1'b0;
            capture    <= fifo_rd_en;
            if (capture) begin
                hold       <= fifo_dout;
                word_ready <= 1'b1;
            // one request in flight at a time: wait out pulse, capture and handoff
            end else if (req && !fifo_rd_en && !word_ready) begin
                if (padding) begin
                    hold       <= pad_fill(PAD_WORD);
                    word_ready <= 1'b1;
                end else if (!fifo_empty) begin
                    fifo_rd_en <= 1'b1;
                    stall      <= '0;
                end else if (stall == SW'(STALL_TIMEOUT)) begin
                    hold       <= pad_fill(PAD_WORD);
                    word_ready <= 1'b1;
                    timed_out  <= 1'b1;
                    stall      <= '0;
                end else begin
                    stall <= stall + SW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/triad_gbe_packer.sv
// Drains 9 compfifo words per burst into one framed 16-bit GbE tx packet.
// Optional TRIAD_TIMESTAMP_EN inserts a start-of-packet timestamp after the count.
module triad_gbe_packer
    import triad_gbe_pkg::*;
#(
    parameter int unsigned PRE_WORDS     = 4,
    parameter int unsigned TRIAD_WORDS   = 9,
    parameter int unsigned STALL_TIMEOUT = 255,
    parameter logic [15:0] HDR_MARK      = HDR_MARK_DEFAULT,
    parameter logic [15:0] PAD_WORD      = PAD_WORD_DEFAULT
) (
    input  logic        fabric_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [47:0] fifo_dout,
    output logic        fifo_rd_en,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [15:0] tx_data,
    output logic        tx_kchar,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        busy,
    output logic [15:0] pkt_count,
    output logic        underrun,
    output logic [15:0] underrun_count
);

    localparam int unsigned PW = $clog2(PRE_WORDS + 1);
    localparam int unsigned WW = $clog2(TRIAD_WORDS + 1);

    state_t        state;
    logic [PW-1:0] pre_idx;
    logic [WW-1:0] word_idx;
    logic [1:0]    beat_idx;
    logic [15:0]   csum;
    logic          ur_flag;
    logic          tx_fire;
    logic [47:0]   hold;
    logic          word_ready;
    logic          timed_out;

    assign tx_fire = tx_valid & tx_ready;
    assign busy    = (state != ST_IDLE);

    triad_fifo_fetch #(
        .STALL_TIMEOUT(STALL_TIMEOUT),
        .PAD_WORD     (PAD_WORD)
    ) u_fetch (
        .clk       (fabric_clk),
        .rst_n     (reset_n),
        .req       (state == ST_FETCH),
        .padding   (ur_flag),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .hold      (hold),
        .word_ready(word_ready),
        .timed_out (timed_out)
    );

`ifdef TRIAD_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    logic [15:0] ts_latch;

    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) ts_cnt <= '0;
        else          ts_cnt <= ts_cnt + 16'd1;
    end
`endif

    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            pre_idx        <= '0;
            word_idx       <= '0;
            beat_idx       <= '0;
            csum           <= '0;
            ur_flag        <= 1'b0;
            tx_valid       <= 1'b0;
            tx_data        <= '0;
            tx_kchar       <= 1'b0;
            tx_sof         <= 1'b0;
            tx_eof         <= 1'b0;
            pkt_count      <= '0;
            underrun       <= 1'b0;
            underrun_count <= '0;
`ifdef TRIAD_TIMESTAMP_EN
            ts_latch       <= '0;
`endif
        end else begin
            underrun <= 1'b0;
            // tx_* registers always hold the beat on offer; they advance only on a transfer
            case (state)
                ST_IDLE: if (enable && !fifo_empty) begin
                    state    <= ST_PRE;
                    tx_valid <= 1'b1;
                    tx_data  <= PREAMBLE_WORD;
                    tx_kchar <= 1'b1;
                    pre_idx  <= '0;
                    word_idx <= '0;
                    csum     <= '0;
                    ur_flag  <= 1'b0;
`ifdef TRIAD_TIMESTAMP_EN
                    ts_latch <= ts_cnt;
`endif
                end
                ST_PRE: if (tx_fire) begin
                    if (pre_idx == PW'(PRE_WORDS - 1)) begin
                        state    <= ST_HDR;
                        tx_data  <= HDR_MARK;
                        tx_kchar <= 1'b0;
                        tx_sof   <= 1'b1;
                    end else begin
                        pre_idx <= pre_idx + PW'(1);
                    end
                end
                ST_HDR: if (tx_fire) begin
                    state   <= ST_CNT;
                    tx_data <= pkt_count;
                    tx_sof  <= 1'b0;
                end
                ST_CNT: if (tx_fire) begin
`ifdef TRIAD_TIMESTAMP_EN
                    state   <= ST_TS;
                    tx_data <= ts_latch;
`else
                    state    <= ST_FETCH;
                    tx_valid <= 1'b0;
`endif
                end
`ifdef TRIAD_TIMESTAMP_EN
                ST_TS: if (tx_fire) begin
                    state    <= ST_FETCH;
                    tx_valid <= 1'b0;
                end
`endif
                ST_FETCH: if (word_ready) begin
                    state    <= ST_DATA;
                    tx_valid <= 1'b1;
                    tx_data  <= hold[15:0];
                    beat_idx <= '0;
                    if (timed_out) ur_flag <= 1'b1;
                end
                ST_DATA: if (tx_fire) begin
                    csum <= csum ^ tx_data;
                    if (beat_idx == 2'(BEATS_PER_WORD - 1)) begin
                        if (word_idx == WW'(TRIAD_WORDS - 1)) begin
                            state   <= ST_CSUM;
                            tx_data <= csum ^ tx_data;
                        end else begin
                            state    <= ST_FETCH;
                            word_idx <= word_idx + WW'(1);
                            tx_valid <= 1'b0;
                        end
                    end else begin
                        beat_idx <= beat_idx + 2'd1;
                        tx_data  <= (beat_idx == 2'd0) ? hold[31:16] : hold[47:32];
                    end
                end
                ST_CSUM: if (tx_fire) begin
                    state   <= ST_EOP;
                    tx_data <= EOP_WORD;
                    tx_eof  <= 1'b1;
                end
                ST_EOP: if (tx_fire) begin
                    state     <= ST_IDLE;
                    tx_valid  <= 1'b0;
                    tx_data   <= '0;
                    tx_eof    <= 1'b0;
                    pkt_count <= pkt_count + 16'd1;
                    underrun  <= ur_flag;
                    if (ur_flag && (underrun_count != 16'hFFFF))
                        underrun_count <= underrun_count + 16'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_triad_gbe_packer.sv
// Self-checking bench for triad_gbe_packer: FIFO model, beat monitor and a
// frame-level reference model built from word lists.
module tb_triad_gbe_packer;

`ifdef TRIAD_TIMESTAMP_EN
    localparam int unsigned DATA_OFF = 7;
`else
    localparam int unsigned DATA_OFF = 6;
`endif
    localparam int unsigned FL = DATA_OFF + 29;

    logic        fabric_clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        fifo_empty;
    logic [47:0] fifo_dout;
    logic        fifo_rd_en;
    logic        tx_ready = 1'b0;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_kchar, tx_sof, tx_eof, busy, underrun;
    logic [15:0] pkt_count, underrun_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    triad_gbe_packer dut (
        .fabric_clk(fabric_clk), .reset_n(reset_n), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_kchar(tx_kchar), .tx_sof(tx_sof), .tx_eof(tx_eof), .busy(busy),
        .pkt_count(pkt_count), .underrun(underrun), .underrun_count(underrun_count)
    );

    always #5 fabric_clk = ~fabric_clk;

    // FIFO model: writes from the stimulus side, reads on rd_en, data one cycle later
    logic [47:0] fifo_mem [64];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr    <= 0;
            fifo_dout <= '0;
        end else if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_dout <= fifo_mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int unsigned ready_mode = 0;
    always @(posedge fabric_clk) begin
        #2;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic [15:0] tb_cyc;
    always @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) tb_cyc <= '0;
        else          tb_cyc <= tb_cyc + 16'd1;
    end

    // Monitor: transferred beats, hold-stability, read pulses, packet start times
    logic [18:0] beats [$];
    logic [15:0] ts_q [$];
    int unsigned eof_seen = 0, rd_pulses = 0, rd_empty_err = 0, stab_err = 0, ur_pulses = 0;
    logic        prev_stall = 1'b0, prev_valid = 1'b0;
    logic [18:0] prev_beat = '0;

    always @(negedge fabric_clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (tx_valid && tx_ready) begin
                beats.push_back({tx_kchar, tx_sof, tx_eof, tx_data});
                if (tx_eof) eof_seen++;
            end
            if (prev_stall && ({tx_kchar, tx_sof, tx_eof, tx_data} != prev_beat)) stab_err++;
            if (tx_valid && !prev_valid && tx_kchar) ts_q.push_back(tb_cyc - 16'd1);
            if (fifo_rd_en) rd_pulses++;
            if (fifo_rd_en && fifo_empty) rd_empty_err++;
            if (underrun) ur_pulses++;
            prev_stall = tx_valid && !tx_ready;
            prev_valid = tx_valid;
            prev_beat  = {tx_kchar, tx_sof, tx_eof, tx_data};
        end
    end

    // Reference model: frame as a list of {kchar,sof,eof,data} beats
    logic [47:0] mw [9];
    logic [18:0] exp_q [$];
    logic [15:0] model_csum;

    function automatic void build_frame(input int unsigned nvalid, input logic [15:0] cnt,
                                        input logic [15:0] ts);
        logic [47:0] w;
        logic [15:0] d;
        exp_q.delete();
        model_csum = '0;
        for (int unsigned i = 0; i < 4; i++) exp_q.push_back({3'b100, 16'h50BC});
        exp_q.push_back({3'b010, 16'hC0DE});
        exp_q.push_back({3'b000, cnt});
`ifdef TRIAD_TIMESTAMP_EN
        exp_q.push_back({3'b000, ts});
`else
        if (ts != ts) exp_q.delete();
`endif
        for (int unsigned k = 0; k < 9; k++) begin
            w = (k < nvalid) ? mw[k] : {3{16'hDEAD}};
            for (int unsigned s = 0; s < 3; s++) begin
                d = w[16*s +: 16];
                model_csum ^= d;
                exp_q.push_back({3'b000, d});
            end
        end
        exp_q.push_back({3'b000, model_csum});
        exp_q.push_back({3'b001, 16'hF7FE});
    endfunction

    function automatic logic [47:0] pattern_word(input int unsigned k);
        logic [47:0] base = 48'h0003_0002_0001;
        logic [47:0] step = 48'h0001_0001_0001;
        return base + 48'(k) * step;
    endfunction

    function automatic logic [15:0] ts_at(input int unsigned idx);
        return (idx < ts_q.size()) ? ts_q[idx] : 16'h0000;
    endfunction

    task automatic push_word(input logic [47:0] w);
        fifo_mem[wr_ptr % 64] = w;
        wr_ptr++;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        wr_ptr  = 0;
        repeat (3) @(posedge fabric_clk);
        @(negedge fabric_clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (2) @(posedge fabric_clk);
        #1;
        vectors++;
        if ({tx_valid, tx_kchar, tx_sof, tx_eof, fifo_rd_en, busy, underrun,
             tx_data, pkt_count, underrun_count} !== 55'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b busy=%b rd=%b data=%h cnt=%h urc=%h, expected all 0",
                     tx_valid, busy, fifo_rd_en, tx_data, pkt_count, underrun_count);
        end
    endtask

    task automatic run_stream(input int unsigned mode, input string name);
        int unsigned base, rd0, st0, e0, t0, n;
        logic [18:0] got;
        apply_reset();
        ready_mode = mode;
        for (int unsigned k = 0; k < 9; k++) begin
            mw[k] = pattern_word(k);
            push_word(mw[k]);
        end
        base = beats.size(); rd0 = rd_pulses; st0 = stab_err; e0 = eof_seen; t0 = ts_q.size();
        enable = 1'b1;
        n = 0;
        while (eof_seen < e0 + 1 && n < 3000) begin @(posedge fabric_clk); n++; end
        repeat (3) @(posedge fabric_clk);
        #1;
        vectors++;
        if (eof_seen != e0 + 1) begin
            miscompares++;
            $display("FAIL %s_eof: got %0d packets, expected 1", name, eof_seen - e0);
        end
        build_frame(9, 16'h0000, ts_at(t0));
        for (int unsigned i = 0; i < exp_q.size(); i++) begin
            got = (base + i < beats.size()) ? beats[base + i] : 19'bx;
            vectors++;
            if (got !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s_beat%0d: got %h, expected %h", name, i, got, exp_q[i]);
            end
        end
        vectors++;
        if (rd_pulses - rd0 != 9) begin
            miscompares++;
            $display("FAIL %s_rd_pulses: got %0d, expected 9", name, rd_pulses - rd0);
        end
        vectors++;
        if (pkt_count !== 16'd1) begin
            miscompares++;
            $display("FAIL %s_pkt_count: got %h, expected 0001", name, pkt_count);
        end
        vectors++;
        if (stab_err != st0) begin
            miscompares++;
            $display("FAIL %s_hold_stable: got %0d unstable stalls, expected 0", name, stab_err - st0);
        end
        vectors++;
        if (busy !== 1'b0 || rd_empty_err != 0) begin
            miscompares++;
            $display("FAIL %s_idle: got busy=%b rd_when_empty=%0d, expected 0/0", name, busy, rd_empty_err);
        end
    endtask

    task automatic test_stream();
        run_stream(0, "stream");
    endtask

    task automatic test_backpressure();
        run_stream(1, "backpressure");
    endtask

    task automatic test_underrun();
        int unsigned base, rd0, u0, e0, t0, n;
        logic [18:0] got;
        apply_reset();
        ready_mode = 2;
        for (int unsigned k = 0; k < 9; k++) mw[k] = {16'($urandom), 32'($urandom)};
        for (int unsigned k = 0; k < 5; k++) push_word(mw[k]);
        base = beats.size(); rd0 = rd_pulses; u0 = ur_pulses; e0 = eof_seen; t0 = ts_q.size();
        enable = 1'b1;
        n = 0;
        while (eof_seen < e0 + 1 && n < 4000) begin @(posedge fabric_clk); n++; end
        repeat (300) @(posedge fabric_clk);
        #1;
        vectors++;
        if (eof_seen != e0 + 1) begin
            miscompares++;
            $display("FAIL underrun_eof: got %0d packets, expected 1", eof_seen - e0);
        end
        build_frame(5, 16'h0000, ts_at(t0));
        for (int unsigned i = 0; i < exp_q.size(); i++) begin
            got = (base + i < beats.size()) ? beats[base + i] : 19'bx;
            vectors++;
            if (got !== exp_q[i]) begin
                miscompares++;
                $display("FAIL underrun_beat%0d: got %h, expected %h", i, got, exp_q[i]);
            end
        end
        vectors++;
        if (ur_pulses - u0 != 1) begin
            miscompares++;
            $display("FAIL underrun_pulses: got %0d, expected 1", ur_pulses - u0);
        end
        vectors++;
        if (underrun_count !== 16'd1) begin
            miscompares++;
            $display("FAIL underrun_count: got %h, expected 0001", underrun_count);
        end
        vectors++;
        if (rd_pulses - rd0 != 5) begin
            miscompares++;
            $display("FAIL underrun_rd_pulses: got %0d, expected 5", rd_pulses - rd0);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned base, rd0, e0, t0, n;
        logic [47:0] words [18];
        logic [18:0] got;
        apply_reset();
        ready_mode = 2;
        for (int unsigned k = 0; k < 18; k++) begin
            words[k] = {16'($urandom), 32'($urandom)};
            push_word(words[k]);
        end
        push_word(48'h1234_5678_9ABC);
        base = beats.size(); rd0 = rd_pulses; e0 = eof_seen; t0 = ts_q.size();
        enable = 1'b1;
        n = 0;
        while (beats.size() - base < FL + DATA_OFF + 10 && n < 3000) begin @(posedge fabric_clk); n++; end
        #1;
        enable = 1'b0;
        n = 0;
        while (eof_seen < e0 + 2 && n < 3000) begin @(posedge fabric_clk); n++; end
        repeat (60) @(posedge fabric_clk);
        #1;
        vectors++;
        if (beats.size() - base != 2 * FL) begin
            miscompares++;
            $display("FAIL b2b_beat_total: got %0d, expected %0d", beats.size() - base, 2 * FL);
        end
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned k = 0; k < 9; k++) mw[k] = words[9 * p + k];
            build_frame(9, 16'(p), ts_at(t0 + p));
            for (int unsigned i = 0; i < exp_q.size(); i++) begin
                got = (base + p * FL + i < beats.size()) ? beats[base + p * FL + i] : 19'bx;
                vectors++;
                if (got !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL b2b_pkt%0d_beat%0d: got %h, expected %h", p, i, got, exp_q[i]);
                end
            end
        end
        vectors++;
        if (pkt_count !== 16'd2 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_final: got pkt_count=%h busy=%b, expected 0002/0", pkt_count, busy);
        end
        vectors++;
        if (rd_pulses - rd0 != 18) begin
            miscompares++;
            $display("FAIL b2b_rd_pulses: got %0d, expected 18", rd_pulses - rd0);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned base, e0, t0, n;
        logic [18:0] got;
        apply_reset();
        ready_mode = 0;
        for (int unsigned k = 0; k < 9; k++) begin
            mw[k] = pattern_word(k);
            push_word(mw[k]);
        end
        base = beats.size();
        enable = 1'b1;
        n = 0;
        while (beats.size() - base < DATA_OFF + 9 && n < 1000) begin @(posedge fabric_clk); n++; end
        @(posedge fabric_clk);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({tx_valid, tx_kchar, tx_sof, tx_eof, fifo_rd_en, busy, underrun,
             tx_data, pkt_count, underrun_count} !== 55'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got valid=%b busy=%b data=%h cnt=%h, expected all 0",
                     tx_valid, busy, tx_data, pkt_count);
        end
        wr_ptr = 0;
        repeat (2) @(posedge fabric_clk);
        @(negedge fabric_clk);
        reset_n = 1'b1;
        base = beats.size(); e0 = eof_seen; t0 = ts_q.size();
        for (int unsigned k = 0; k < 9; k++) push_word(mw[k]);
        n = 0;
        while (eof_seen < e0 + 1 && n < 2000) begin @(posedge fabric_clk); n++; end
        repeat (3) @(posedge fabric_clk);
        #1;
        build_frame(9, 16'h0000, ts_at(t0));
        for (int unsigned i = 0; i < exp_q.size(); i++) begin
            got = (base + i < beats.size()) ? beats[base + i] : 19'bx;
            vectors++;
            if (got !== exp_q[i]) begin
                miscompares++;
                $display("FAIL midreset_beat%0d: got %h, expected %h", i, got, exp_q[i]);
            end
        end
        vectors++;
        if (pkt_count !== 16'd1) begin
            miscompares++;
            $display("FAIL midreset_pkt_count: got %h, expected 0001", pkt_count);
        end
    endtask

`ifdef TRIAD_TIMESTAMP_EN
    task automatic test_timestamp();
        int unsigned base, e0, t0, n;
        logic [18:0] got;
        logic [15:0] t1_csum;
        apply_reset();
        ready_mode = 0;
        for (int unsigned k = 0; k < 9; k++) mw[k] = pattern_word(k);
        build_frame(9, 16'h0000, 16'h0000);
        t1_csum = model_csum;
        repeat ($urandom_range(5, 40)) @(posedge fabric_clk);
        #1;
        for (int unsigned k = 0; k < 9; k++) push_word(mw[k]);
        base = beats.size(); e0 = eof_seen; t0 = ts_q.size();
        enable = 1'b1;
        n = 0;
        while (eof_seen < e0 + 1 && n < 2000) begin @(posedge fabric_clk); n++; end
        repeat (3) @(posedge fabric_clk);
        #1;
        build_frame(9, 16'h0000, ts_at(t0));
        for (int unsigned i = 0; i < exp_q.size(); i++) begin
            got = (base + i < beats.size()) ? beats[base + i] : 19'bx;
            vectors++;
            if (got !== exp_q[i]) begin
                miscompares++;
                $display("FAIL ts_beat%0d: got %h, expected %h", i, got, exp_q[i]);
            end
        end
        got = (base + FL - 2 < beats.size()) ? beats[base + FL - 2] : 19'bx;
        vectors++;
        if (got !== {3'b000, t1_csum}) begin
            miscompares++;
            $display("FAIL ts_checksum: got %h, expected %h", got, {3'b000, t1_csum});
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
`ifdef TRIAD_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
